// File: rtl/ball_motion.sv
// Ball kinematics for a two-court volley game: serve spawn, per-frame gravity
// integration with collision-corrected velocity, wall clamp, landing and hold.
module ball_motion #(
  parameter int GRAVITY     = 1,
  parameter int VMAX        = 60,
  parameter int GROUND_Y    = 440,
  parameter int NET_X       = 310,
  parameter int SERVE_X_L   = 96,
  parameter int SERVE_X_R   = 544,
  parameter int SERVE_Y     = 100,
  parameter int HOLD_FRAMES = 60,
  parameter int X_MIN       = 20,
  parameter int X_MAX       = 610
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               serve,
  input  logic               bounce_valid,
  input  logic signed [9:0]  bounce_v_x,
  input  logic signed [9:0]  bounce_v_y,
  output logic signed [10:0] ball_pos_x,
  output logic signed [10:0] ball_pos_y,
  output logic signed [9:0]  ball_v_x,
  output logic signed [9:0]  ball_v_y,
  output logic [1:0]         state,
  output logic               ground_hit,
  output logic               point_to
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FLY  = 2'b01,
    ST_LAND = 2'b10
  } state_e;

  localparam logic signed [11:0] GRAVITY_P = 12'(GRAVITY);
  localparam logic signed [11:0] VMAX_P    = 12'(VMAX);
  localparam logic signed [11:0] VMIN_P    = 12'(-VMAX);
  localparam logic signed [11:0] GROUND_P  = 12'(GROUND_Y);
  localparam logic signed [11:0] NET_P     = 12'(NET_X);
  localparam logic signed [11:0] XMIN_P    = 12'(X_MIN);
  localparam logic signed [11:0] XMAX_P    = 12'(X_MAX);
  localparam logic signed [10:0] GROUND_11 = 11'(GROUND_Y);
  localparam logic signed [10:0] SX_L_P    = 11'(SERVE_X_L);
  localparam logic signed [10:0] SX_R_P    = 11'(SERVE_X_R);
  localparam logic signed [10:0] SY_P      = 11'(SERVE_Y);
  localparam logic [15:0]        HOLD_P    = 16'(HOLD_FRAMES);

  function automatic logic signed [11:0] sext10(input logic signed [9:0] v);
    return {{2{v[9]}}, v};
  endfunction

  function automatic logic signed [11:0] sext11(input logic signed [10:0] v);
    return {v[10], v};
  endfunction

  function automatic logic signed [11:0] clamp12(input logic signed [11:0] v,
                                                 input logic signed [11:0] lo,
                                                 input logic signed [11:0] hi);
    if (v < lo) begin
      return lo;
    end else if (v > hi) begin
      return hi;
    end else begin
      return v;
    end
  endfunction

  state_e             state_q, state_d;
  logic signed [10:0] pos_x_q, pos_x_d;
  logic signed [10:0] pos_y_q, pos_y_d;
  logic signed [9:0]  v_x_q, v_x_d;
  logic signed [9:0]  v_y_q, v_y_d;
  logic               ground_hit_q, ground_hit_d;
  logic               point_to_q, point_to_d;
  logic [15:0]        hold_cnt_q, hold_cnt_d;

  logic signed [11:0] v_x_sel, v_y_sel;
  logic signed [11:0] v_x_n, v_y_n;
  logic signed [11:0] pos_x_n, pos_y_n;
  logic signed [10:0] spawn_x;

  // Candidate frame step, evaluated every cycle and committed only on a FLY frame_tick
  always_comb begin
    v_x_sel = bounce_valid ? sext10(bounce_v_x) : sext10(v_x_q);
    v_y_sel = bounce_valid ? sext10(bounce_v_y) : sext10(v_y_q);
    v_x_n   = clamp12(v_x_sel, VMIN_P, VMAX_P);
    v_y_n   = clamp12(v_y_sel + GRAVITY_P, VMIN_P, VMAX_P);
    pos_x_n = clamp12(sext11(pos_x_q) + (v_x_n >>> 2), XMIN_P, XMAX_P);
    pos_y_n = sext11(pos_y_q) + (v_y_n >>> 2);
    spawn_x = point_to_q ? SX_R_P : SX_L_P;
  end

  // Next-state and next-output selection for the serve / fly / land sequence
  always_comb begin
    state_d      = state_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    v_x_d        = v_x_q;
    v_y_d        = v_y_q;
    ground_hit_d = 1'b0;
    point_to_d   = point_to_q;
    hold_cnt_d   = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        pos_x_d    = spawn_x;
        pos_y_d    = SY_P;
        v_x_d      = 10'sd0;
        v_y_d      = 10'sd0;
        hold_cnt_d = 16'd0;
        if (serve) begin
          state_d = ST_FLY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLY: begin
        if (frame_tick) begin
          if (pos_y_n >= GROUND_P) begin
            state_d      = ST_LAND;
            pos_x_d      = pos_x_n[10:0];
            pos_y_d      = GROUND_11;
            v_x_d        = 10'sd0;
            v_y_d        = 10'sd0;
            ground_hit_d = 1'b1;
            point_to_d   = (pos_x_n < NET_P);
            hold_cnt_d   = 16'd0;
          end else begin
            pos_x_d = pos_x_n[10:0];
            pos_y_d = pos_y_n[10:0];
            v_x_d   = v_x_n[9:0];
            v_y_d   = v_y_n[9:0];
          end
        end else begin
          state_d = ST_FLY;
        end
      end
      ST_LAND: begin
        if (frame_tick) begin
          // The frame that ends the hold moves nothing; the ball just respawns
          if ((hold_cnt_q + 16'd1) >= HOLD_P) begin
            state_d    = ST_IDLE;
            pos_x_d    = spawn_x;
            pos_y_d    = SY_P;
            v_x_d      = 10'sd0;
            v_y_d      = 10'sd0;
            hold_cnt_d = 16'd0;
          end else begin
            hold_cnt_d = hold_cnt_q + 16'd1;
          end
        end else begin
          state_d = ST_LAND;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        pos_x_d    = spawn_x;
        pos_y_d    = SY_P;
        v_x_d      = 10'sd0;
        v_y_d      = 10'sd0;
        hold_cnt_d = 16'd0;
      end
    endcase
  end

  // State and output registers with asynchronous reset to the left serve spawn
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pos_x_q      <= SX_L_P;
      pos_y_q      <= SY_P;
      v_x_q        <= 10'sd0;
      v_y_q        <= 10'sd0;
      ground_hit_q <= 1'b0;
      point_to_q   <= 1'b0;
      hold_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      v_x_q        <= v_x_d;
      v_y_q        <= v_y_d;
      ground_hit_q <= ground_hit_d;
      point_to_q   <= point_to_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign ball_pos_x = pos_x_q;
  assign ball_pos_y = pos_y_q;
  assign ball_v_x   = v_x_q;
  assign ball_v_y   = v_y_q;
  assign state      = state_q;
  assign ground_hit = ground_hit_q;
  assign point_to   = point_to_q;

endmodule
